// File: rtl/yutorina_bus_master_ctrl_pkg.sv
// Shared definitions for the bus master sequencer: FSM state encodings,
// state width and parameter defaults.
package yutorina_bus_master_ctrl_pkg;

  localparam int unsigned MST_STATE_W = 2;

  typedef enum logic [MST_STATE_W-1:0] {
    YUTORINA_BUS_MST_IDLE   = 2'd0,
    YUTORINA_BUS_MST_REQ    = 2'd1,
    YUTORINA_BUS_MST_ACCESS = 2'd2,
    YUTORINA_BUS_MST_WAIT   = 2'd3
  } mst_state_e;

  localparam int unsigned DEF_ADDR_W   = 30;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_TO_W     = 8;
  localparam int unsigned DEF_TO_LIMIT = 255;

endpackage

// File: rtl/yutorina_bus_timeout.sv
// Slave-response watchdog: counts enabled cycles since the last clear and
// flags the cycle that is the TO_LIMIT-th one (never fires when TO_LIMIT is 0).
module yutorina_bus_timeout #(
  parameter int unsigned TO_W     = 8,
  parameter int unsigned TO_LIMIT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [TO_W-1:0] LAST = TO_W'((TO_LIMIT == 0) ? 0 : TO_LIMIT - 1);

  logic [TO_W-1:0] r_cnt;

  // Saturates on the last allowed cycle so a late clear is never missed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + TO_W'(1);
    end
  end

  assign o_expired = (TO_LIMIT != 0) && i_en && (r_cnt == LAST);

endmodule

// File: rtl/yutorina_bus_master_ctrl.sv
// Per-master bus access sequencer: holds one CPU access, arbitrates for the
// shared bus, strobes the address once and waits for the slave or a timeout.
module yutorina_bus_master_ctrl
  import yutorina_bus_master_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned TO_W     = DEF_TO_W,
  parameter int unsigned TO_LIMIT = DEF_TO_LIMIT
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_req_n,
  input  logic                   i_rw,
  input  logic [ADDR_W-1:0]      i_addr,
  input  logic [DATA_W-1:0]      i_wr_data,
  output logic [DATA_W-1:0]      o_rd_data,
  output logic                   o_ack_n,
  output logic                   o_err_n,
  output logic                   o_busy,
  output logic                   o_bus_req_n,
  input  logic                   i_bus_grant_n,
  output logic                   o_bus_as_n,
  output logic                   o_bus_rw,
  output logic [ADDR_W-1:0]      o_bus_addr,
  output logic [DATA_W-1:0]      o_bus_wr_data,
  input  logic [DATA_W-1:0]      i_bus_rd_data,
  input  logic                   i_bus_rdy_n,
  output logic [MST_STATE_W-1:0] o_state
);

  // Handshakes are active-low levels sampled on the rising edge: req_n only in
  // IDLE, grant_n only in REQ, rdy_n only in ACCESS/WAIT; ack_n is a 1-cycle pulse.
  mst_state_e        r_state, w_state_nxt;
  logic              r_lat_rw, w_lat_rw_nxt;
  logic [ADDR_W-1:0] r_lat_addr, w_lat_addr_nxt;
  logic [DATA_W-1:0] r_lat_wr_data, w_lat_wr_data_nxt;

  logic              r_bus_req_n, w_bus_req_n_nxt;
  logic              r_bus_as_n, w_bus_as_n_nxt;
  logic              r_ack_n, w_ack_n_nxt;
  logic              r_err_n, w_err_n_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_bus_rw, w_bus_rw_nxt;
  logic [ADDR_W-1:0] r_bus_addr, w_bus_addr_nxt;
  logic [DATA_W-1:0] r_bus_wr_data, w_bus_wr_data_nxt;
  logic [DATA_W-1:0] r_rd_data, w_rd_data_nxt;

  logic w_grant, w_in_xfer, w_rdy, w_expired, w_timeout, w_done;

  assign w_grant   = (r_state == YUTORINA_BUS_MST_REQ) && !i_bus_grant_n;
  assign w_in_xfer = (r_state == YUTORINA_BUS_MST_ACCESS) || (r_state == YUTORINA_BUS_MST_WAIT);
  assign w_rdy     = w_in_xfer && !i_bus_rdy_n;
  assign w_timeout = w_in_xfer && i_bus_rdy_n && w_expired;
  assign w_done    = w_rdy || w_timeout;

  yutorina_bus_timeout #(
    .TO_W     (TO_W),
    .TO_LIMIT (TO_LIMIT)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (w_grant),
    .i_en      (w_in_xfer),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= YUTORINA_BUS_MST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      YUTORINA_BUS_MST_IDLE:   if (!i_req_n) w_state_nxt = YUTORINA_BUS_MST_REQ;
      YUTORINA_BUS_MST_REQ:    if (!i_bus_grant_n) w_state_nxt = YUTORINA_BUS_MST_ACCESS;
      YUTORINA_BUS_MST_ACCESS: w_state_nxt = w_done ? YUTORINA_BUS_MST_IDLE : YUTORINA_BUS_MST_WAIT;
      YUTORINA_BUS_MST_WAIT:   if (w_done) w_state_nxt = YUTORINA_BUS_MST_IDLE;
      default:                 w_state_nxt = YUTORINA_BUS_MST_IDLE;
    endcase
  end

  always_comb begin
    w_lat_rw_nxt      = r_lat_rw;
    w_lat_addr_nxt    = r_lat_addr;
    w_lat_wr_data_nxt = r_lat_wr_data;
    w_bus_req_n_nxt   = r_bus_req_n;
    w_bus_as_n_nxt    = 1'b1;
    w_ack_n_nxt       = 1'b1;
    w_err_n_nxt       = 1'b1;
    w_busy_nxt        = r_busy;
    w_bus_rw_nxt      = r_bus_rw;
    w_bus_addr_nxt    = r_bus_addr;
    w_bus_wr_data_nxt = r_bus_wr_data;
    w_rd_data_nxt     = r_rd_data;
    case (r_state)
      YUTORINA_BUS_MST_IDLE: begin
        // Dropping bus_req_n here forces re-arbitration between accesses.
        w_bus_req_n_nxt = 1'b1;
        w_busy_nxt      = 1'b0;
        if (!i_req_n) begin
          w_lat_rw_nxt      = i_rw;
          w_lat_addr_nxt    = i_addr;
          w_lat_wr_data_nxt = i_wr_data;
          w_bus_req_n_nxt   = 1'b0;
          w_busy_nxt        = 1'b1;
        end
      end
      YUTORINA_BUS_MST_REQ: begin
        if (!i_bus_grant_n) begin
          w_bus_rw_nxt      = r_lat_rw;
          w_bus_addr_nxt    = r_lat_addr;
          w_bus_wr_data_nxt = r_lat_wr_data;
          w_bus_as_n_nxt    = 1'b0;
        end
      end
      YUTORINA_BUS_MST_ACCESS, YUTORINA_BUS_MST_WAIT: begin
        if (w_done) begin
          w_rd_data_nxt     = (r_lat_rw && w_rdy) ? i_bus_rd_data : '0;
          w_ack_n_nxt       = 1'b0;
          w_err_n_nxt       = !w_timeout;
          w_bus_req_n_nxt   = 1'b1;
          w_busy_nxt        = 1'b0;
          w_bus_rw_nxt      = 1'b1;
          w_bus_addr_nxt    = '0;
          w_bus_wr_data_nxt = '0;
        end
      end
      default: begin
        w_bus_req_n_nxt = 1'b1;
        w_busy_nxt      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lat_rw      <= 1'b1;
      r_lat_addr    <= '0;
      r_lat_wr_data <= '0;
      r_bus_req_n   <= 1'b1;
      r_bus_as_n    <= 1'b1;
      r_ack_n       <= 1'b1;
      r_err_n       <= 1'b1;
      r_busy        <= 1'b0;
      r_bus_rw      <= 1'b1;
      r_bus_addr    <= '0;
      r_bus_wr_data <= '0;
      r_rd_data     <= '0;
    end else begin
      r_lat_rw      <= w_lat_rw_nxt;
      r_lat_addr    <= w_lat_addr_nxt;
      r_lat_wr_data <= w_lat_wr_data_nxt;
      r_bus_req_n   <= w_bus_req_n_nxt;
      r_bus_as_n    <= w_bus_as_n_nxt;
      r_ack_n       <= w_ack_n_nxt;
      r_err_n       <= w_err_n_nxt;
      r_busy        <= w_busy_nxt;
      r_bus_rw      <= w_bus_rw_nxt;
      r_bus_addr    <= w_bus_addr_nxt;
      r_bus_wr_data <= w_bus_wr_data_nxt;
      r_rd_data     <= w_rd_data_nxt;
    end
  end

  assign o_rd_data     = r_rd_data;
  assign o_ack_n       = r_ack_n;
  assign o_err_n       = r_err_n;
  assign o_busy        = r_busy;
  assign o_bus_req_n   = r_bus_req_n;
  assign o_bus_as_n    = r_bus_as_n;
  assign o_bus_rw      = r_bus_rw;
  assign o_bus_addr    = r_bus_addr;
  assign o_bus_wr_data = r_bus_wr_data;
  assign o_state       = r_state;

endmodule
